add_pipe: RTL and testbench

ADD_PIPE -- requirements
Module: add_pipe

---
 rtl/add_pkg.sv | 11 +
 rtl/add_seg.sv | 50 +++++
 rtl/add_pipe.sv | 134 +++++++++++++
 tb/tb_add_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared defaults and the stage-count helper for the segmented pipelined adder.
package add_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    function automatic int num_stages(input int width, input int seg);
        return (seg > 0) ? width / seg : 0;
    endfunction

endpackage

// File: rtl/add_seg.sv
// One carry segment: SEG-bit combinational adder feeding registered sum, carry and valid.
// Only the most-significant segment builds the signed-overflow flag.
module add_seg #(
    parameter int SEG  = 8,
    parameter bit LAST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           valid_in,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic           valid,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           ovf
);

    logic [SEG:0] raw;

    assign raw = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

    // NOTE: registers take non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (en) begin
            valid <= valid_in;
            sum   <= raw[SEG-1:0];
            cout  <= raw[SEG];
        end
    end

    if (LAST) begin : g_ovf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf <= 1'b0;
            end else if (en) begin
                ovf <= (a[SEG-1] == b[SEG-1]) && (raw[SEG-1] != a[SEG-1]);
            end
        end
    end else begin : g_no_ovf
        assign ovf = 1'b0;
    end

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract: WIDTH bits split into WIDTH/SEG carry segments, one per stage,
// with skew registers keeping each operation's operand and result segments aligned.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N = num_stages(WIDTH, SEG);

    if ((SEG < 1) || (WIDTH < SEG) || ((WIDTH % ((SEG < 1) ? 1 : SEG)) != 0)) begin : g_bad_params
        $error("add_pipe: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [N-1:0]     valid_q;
    logic [N-1:0]     carry_q;
    logic [N-1:0]     ovf_q;
    logic [SEG-1:0]   sum_q [N];
    // [stage][segment]: operand segments still waiting to be added, and finished result segments
    logic [SEG-1:0]   a_sk  [N][N];
    logic [SEG-1:0]   b_sk  [N][N];
    logic [SEG-1:0]   r_sk  [N][N];

    // The whole pipeline advances together; it only stops when the output is held.
    assign en        = !valid_q[N-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[N-1];
    assign cout      = carry_q[N-1];
    assign ovf       = |ovf_q;
    assign b_eff     = sub ? ~b : b;
    assign c0        = sub | cin;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic           seg_cin;
        logic           seg_valid;

        if (k == 0) begin : g_head
            assign seg_a     = a[SEG-1:0];
            assign seg_b     = b_eff[SEG-1:0];
            assign seg_cin   = c0;
            assign seg_valid = in_valid;
        end else begin : g_body
            assign seg_a     = a_sk[k-1][k];
            assign seg_b     = b_sk[k-1][k];
            assign seg_cin   = carry_q[k-1];
            assign seg_valid = valid_q[k-1];
        end

        add_seg #(
            .SEG  (SEG),
            .LAST (k == N - 1)
        ) u_seg (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .valid_in (seg_valid),
            .a        (seg_a),
            .b        (seg_b),
            .cin      (seg_cin),
            .valid    (valid_q[k]),
            .sum      (sum_q[k]),
            .cout     (carry_q[k]),
            .ovf      (ovf_q[k])
        );

        // NOTE: operand skew registers carry no reset; their contents are ignored
        // until a stage valid bit, which is reset, marks them as live.
        for (genvar j = k + 1; j < N; j++) begin : g_op_skew
            if (k == 0) begin : g_load
                always_ff @(posedge clk) begin
                    if (en) begin
                        a_sk[0][j] <= a[j*SEG +: SEG];
                        b_sk[0][j] <= b_eff[j*SEG +: SEG];
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (en) begin
                        a_sk[k][j] <= a_sk[k-1][j];
                        b_sk[k][j] <= b_sk[k-1][j];
                    end
                end
            end
        end

        // Finished low segments ride along; the last stage's copy forms part of s.
        for (genvar j = 0; j < k; j++) begin : g_res_skew
            logic [SEG-1:0] d;

            if (j == k - 1) begin : g_fresh
                assign d = sum_q[j];
            end else begin : g_carry_on
                assign d = r_sk[k-1][j];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sk[k][j] <= '0;
                end else if (en) begin
                    r_sk[k][j] <= d;
                end
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_sum_out
        if (j == N - 1) begin : g_top_seg
            assign s[j*SEG +: SEG] = sum_q[j];
        end else begin : g_low_seg
            assign s[j*SEG +: SEG] = r_sk[N-1][j];
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: three configurations (32/8, 64/16, 8/8) checked against
// an arithmetic reference model, with directed corner cases, stall, reset and random traffic.
module tb_add_pipe;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    localparam int NI = 3;
    int wid [NI] = '{32, 64, 8};
    int nst [NI] = '{4, 4, 1};

    logic        clk;
    logic        rst;
    logic        in_valid_v  [NI];
    logic        out_ready_v [NI];
    logic        sub_v       [NI];
    logic        cin_v       [NI];
    logic [63:0] a_v         [NI];
    logic [63:0] b_v         [NI];

    logic        in_ready_w  [NI];
    logic        out_valid_w [NI];
    logic        cout_w      [NI];
    logic        ovf_w       [NI];
    logic [63:0] s_w         [NI];
    logic [31:0] s32;
    logic [63:0] s64;
    logic [7:0]  s8;

    int   n_compared = 0;
    int   n_mismatch = 0;
    res_t exp_q [NI][$];
    logic acc      [NI];
    logic held_v   [NI];
    int   popped   [NI];
    int   accepted [NI];

    assign s_w[0] = {32'd0, s32};
    assign s_w[1] = s64;
    assign s_w[2] = {56'd0, s8};

    add_pipe #(.WIDTH(32), .SEG(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .a(a_v[0][31:0]), .b(b_v[0][31:0]), .sub(sub_v[0]), .cin(cin_v[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
        .s(s32), .cout(cout_w[0]), .ovf(ovf_w[0])
    );

    add_pipe #(.WIDTH(64), .SEG(16)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .a(a_v[1]), .b(b_v[1]), .sub(sub_v[1]), .cin(cin_v[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
        .s(s64), .cout(cout_w[1]), .ovf(ovf_w[1])
    );

    add_pipe #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .sub(sub_v[2]), .cin(cin_v[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]),
        .s(s8), .cout(cout_w[2]), .ovf(ovf_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s[%0d]: observed 0x%0h, expected 0x%0h", tag, inst, obs, exp);
        end
    endtask

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain modular and signed arithmetic on the operand values.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sb, input logic ci);
        logic [64:0]        full;
        logic signed [66:0] sa, sbv, sr, lim;
        res_t               r;
        if (sb) full = {1'b0, a} - {1'b0, b};
        else    full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        r.s    = full[63:0] & width_mask(w);
        r.cout = sb ? (a >= b) : full[w];
        sa  = {3'b000, a};
        sbv = {3'b000, b};
        if (a[w-1]) sa  = sa  - (67'sd1 <<< w);
        if (b[w-1]) sbv = sbv - (67'sd1 <<< w);
        sr  = sb ? (sa - sbv) : (sa + sbv + (ci ? 67'sd1 : 67'sd0));
        lim = 67'sd1 <<< (w - 1);
        r.ovf = (sr >= lim) || (sr < -lim);
        return r;
    endfunction

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] v;
        case ($urandom_range(7))
            0:       v = '1;
            1:       v = '0;
            2:       v = 64'd1 << (w - 1);
            3:       v = (64'd1 << (w - 1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & width_mask(w);
    endfunction

    // Scoreboard: handshakes seen away from the clock edge, results compared in order.
    always @(negedge clk) begin : monitor
        res_t r;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                held_v[i] = 1'b0;
                acc[i]    = 1'b0;
            end else begin
                check("in_ready_rule", i, 64'(in_ready_w[i]), 64'(!out_valid_w[i] || out_ready_v[i]));
                if (held_v[i]) check("hold_valid", i, 64'(out_valid_w[i]), 64'd1);
                if (out_valid_w[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("spurious_out", i, 64'(out_valid_w[i]), 64'd0);
                    end else begin
                        r = exp_q[i][0];
                        check("s", i, s_w[i], r.s);
                        check("cout", i, 64'(cout_w[i]), 64'(r.cout));
                        check("ovf", i, 64'(ovf_w[i]), 64'(r.ovf));
                        if (out_ready_v[i]) begin
                            void'(exp_q[i].pop_front());
                            popped[i]++;
                        end
                    end
                end
                held_v[i] = out_valid_w[i] && !out_ready_v[i];
                acc[i]    = in_valid_v[i] && in_ready_w[i];
                if (acc[i]) begin
                    exp_q[i].push_back(model(wid[i], a_v[i], b_v[i], sub_v[i], cin_v[i]));
                    accepted[i]++;
                end
            end
        end
    end

    // One operation into an empty pipeline: checks latency and the exact result.
    task automatic directed(input int i, input logic [63:0] a, input logic [63:0] b,
                            input logic sb, input logic ci, input logic [63:0] es,
                            input logic ec, input logic eo, input string tag);
        int lat;
        a_v[i] = a; b_v[i] = b; sub_v[i] = sb; cin_v[i] = ci; in_valid_v[i] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[i] = 1'b0;
        lat = 1;
        while (!out_valid_w[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, i, 64'(lat), 64'(nst[i]));
        check({tag, "_s"}, i, s_w[i], es);
        check({tag, "_cout"}, i, 64'(cout_w[i]), 64'(ec));
        check({tag, "_ovf"}, i, 64'(ovf_w[i]), 64'(eo));
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        logic [63:0] oa [6];
        logic [63:0] ob [6];
        logic        osb [6];
        res_t        r1;
        int          issued, cyc, got0, guard, base1, base2;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; held_v[i] = 1'b0; acc[i] = 1'b0;
            popped[i] = 0; accepted[i] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_out_valid", i, 64'(out_valid_w[i]), 64'd0);
            check("rst_s", i, s_w[i], 64'd0);
            check("rst_cout", i, 64'(cout_w[i]), 64'd0);
            check("rst_ovf", i, 64'(ovf_w[i]), 64'd0);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check("in_ready_after_rst", i, 64'(in_ready_w[i]), 64'd1);
            out_ready_v[i] = 1'b1;
        end

        directed(0, 64'hFFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, "wrap_cin");
        directed(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, "pos_ovf");
        directed(0, 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        directed(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, "sub64");
        directed(2, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, "n1_ovf");

        // Six back-to-back operations with a three-cycle output stall mid-stream.
        for (int k = 0; k < 6; k++) begin
            oa[k] = rnd_op(32); ob[k] = rnd_op(32); osb[k] = 1'($urandom_range(1));
        end
        r1 = model(32, oa[1], ob[1], osb[1], 1'b0);
        got0 = popped[0];
        issued = 0;
        cyc = 0;
        while (issued < 6 && cyc < 50) begin
            out_ready_v[0] = !(cyc >= 5 && cyc <= 7);
            a_v[0] = oa[issued]; b_v[0] = ob[issued]; sub_v[0] = osb[issued]; cin_v[0] = 1'b0;
            in_valid_v[0] = 1'b1;
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check("stall_in_ready", 0, 64'(in_ready_w[0]), 64'd0);
                check("stall_out_valid", 0, 64'(out_valid_w[0]), 64'd1);
                check("stall_s", 0, s_w[0], r1.s);
            end
            if (in_ready_w[0]) issued++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        guard = 0;
        while (popped[0] < got0 + 6 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        check("stream_count", 0, 64'(popped[0] - got0), 64'd6);

        // Reset with three operations in flight, the oldest held at the output.
        out_ready_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_v[0] = rnd_op(32); b_v[0] = rnd_op(32); sub_v[0] = 1'b0; cin_v[0] = 1'b0;
            in_valid_v[0] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_v[0] = 1'b0;
        guard = 0;
        while (!out_valid_w[0] && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("inflight_visible", 0, 64'(out_valid_w[0]), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_now_out_valid", 0, 64'(out_valid_w[0]), 64'd0);
        check("rst_now_s", 0, s_w[0], 64'd0);
        check("rst_now_cout", 0, 64'(cout_w[0]), 64'd0);
        for (int i = 0; i < NI; i++) exp_q[i].delete();
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 0, 64'(in_ready_w[0]), 64'd1);
        out_ready_v[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("no_ghost_out", 0, 64'(out_valid_w[0]), 64'd0);
        end

        // Random traffic with random stalls on both sides of every instance.
        base1 = accepted[1];
        base2 = accepted[2];
        cyc = 0;
        while ((accepted[1] - base1 < 10000 || accepted[2] - base2 < 10000) && cyc < 40000) begin
            for (int i = 0; i < NI; i++) begin
                if (!in_valid_v[i] || acc[i]) begin
                    in_valid_v[i] = ($urandom_range(3) != 0);
                    a_v[i]   = rnd_op(wid[i]);
                    b_v[i]   = rnd_op(wid[i]);
                    sub_v[i] = 1'($urandom_range(1));
                    cin_v[i] = 1'($urandom_range(1));
                end
                out_ready_v[i] = ($urandom_range(3) != 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_ops_64", 1, 64'(accepted[1] - base1 >= 10000), 64'd1);
        check("rand_ops_8", 2, 64'(accepted[2] - base2 >= 10000), 64'd1);

        for (int i = 0; i < NI; i++) begin
            in_valid_v[i] = 1'b0;
            out_ready_v[i] = 1'b1;
        end
        guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < NI; i++) check("drain_empty", i, 64'(exp_q[i].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
